// File: rtl/vpu_stream_if.sv
// Element/word stream bundle for vpu_stream: IN_LANES-wide input beats, OUT_LANES-wide masked output words.
// slave = the post-processing unit's view; master = the upstream/downstream side driving it.
interface vpu_stream_if #(
  parameter int DW        = 32,
  parameter int IN_LANES  = 2,
  parameter int OUT_LANES = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_LANES*DW-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_LANES*DW-1:0] out_data;
  logic [OUT_LANES-1:0]    out_mask;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mask
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_mask
  );
endinterface

// File: rtl/vpu_stream.sv
// Streaming activation (pass/ReLU/clamp/leaky) that packs IN_LANES beats into masked OUT_LANES words.
// One cycle from completing beat to out_valid; in_ready drops while a held word is stalled by out_ready.
module vpu_stream #(
  parameter int DW        = 32,
  parameter int IN_LANES  = 2,
  parameter int OUT_LANES = 8,
  parameter int LEN_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           mode,
  input  logic [LEN_W-1:0]     length,
  input  logic signed [DW-1:0] cfg_clamp,
  input  logic [4:0]           cfg_shift,
  vpu_stream_if.slave          strm,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int PW = $clog2(OUT_LANES) + 1;

  if ((OUT_LANES % IN_LANES) != 0) begin : g_bad_lanes
    $error("vpu_stream: OUT_LANES must be a multiple of IN_LANES");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  state_q;
  logic [3:0]              mode_q;
  logic signed [DW-1:0]    clamp_q;
  logic [4:0]              shift_q;
  logic [LEN_W-1:0]        rem_q;
  logic [PW-1:0]           ptr_q;
  logic [OUT_LANES*DW-1:0] pack_q;
  logic [OUT_LANES-1:0]    packm_q;
  logic                    out_valid_q;
  logic                    last_q;
  logic [OUT_LANES*DW-1:0] out_data_q;
  logic [OUT_LANES-1:0]    out_mask_q;
  logic                    done_q;
  logic                    err_q;

  logic [OUT_LANES*DW-1:0] pack_d;
  logic [OUT_LANES-1:0]    packm_d;
  logic [LEN_W-1:0]        take;
  logic                    in_ready;
  logic                    accept;
  logic                    last_beat;
  logic                    fill;
  logic                    out_fire;

  function automatic logic [DW-1:0] act(input logic signed [DW-1:0] x,
                                        input logic [3:0]           m,
                                        input logic signed [DW-1:0] c,
                                        input logic [4:0]           sh);
    logic signed [DW-1:0] y;
    case (m)
      4'd1:    y = (x > 0) ? x : '0;
      4'd2:    y = (x <= 0) ? '0 : ((x > c) ? c : x);
      4'd3:    y = (x < 0) ? (x >>> sh) : x;
      default: y = x;
    endcase
    return y;
  endfunction

  // Lanes past the remaining element count are dropped, so a short last beat never pollutes the word.
  always_comb begin
    pack_d  = pack_q;
    packm_d = packm_q;
    for (int i = 0; i < IN_LANES; i++) begin
      if (i < int'(rem_q)) begin
        pack_d[(int'(ptr_q) + i)*DW +: DW] = act(strm.in_data[i*DW +: DW], mode_q, clamp_q, shift_q);
        packm_d[int'(ptr_q) + i]           = 1'b1;
      end
    end
  end

  assign in_ready  = (state_q == S_RUN) && (!out_valid_q || strm.out_ready);
  assign accept    = strm.in_valid && in_ready && (rem_q != '0);
  assign take      = (rem_q < LEN_W'(IN_LANES)) ? rem_q : LEN_W'(IN_LANES);
  assign last_beat = (rem_q <= LEN_W'(IN_LANES));
  assign fill      = ((ptr_q + PW'(IN_LANES)) == PW'(OUT_LANES));
  assign out_fire  = out_valid_q && strm.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      clamp_q     <= '0;
      shift_q     <= '0;
      rem_q       <= '0;
      ptr_q       <= '0;
      pack_q      <= '0;
      packm_q     <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            clamp_q <= cfg_clamp;
            shift_q <= cfg_shift;
            rem_q   <= length;
            ptr_q   <= '0;
            if (mode > 4'd3) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (length == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            if (last_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
          // A word loaded here overrides the clear above when both happen together.
          if (accept) begin
            rem_q <= rem_q - take;
            if (fill || last_beat) begin
              out_valid_q <= 1'b1;
              out_data_q  <= pack_d;
              out_mask_q  <= packm_d;
              last_q      <= last_beat;
              pack_q      <= '0;
              packm_q     <= '0;
              ptr_q       <= '0;
            end else begin
              pack_q  <= pack_d;
              packm_q <= packm_d;
              ptr_q   <= ptr_q + PW'(IN_LANES);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign strm.in_ready  = in_ready;
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_mask  = out_mask_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_vpu_stream.sv
// Directed bench for vpu_stream: a queue-based packing model scores every output handshake, plus literal word checks.
module tb_vpu_stream;
  localparam int DW = 32;
  localparam int IL = 2;
  localparam int OL = 8;
  localparam int LW = 8;
  localparam int WW = OL*DW;

  typedef struct packed {
    logic [WW-1:0] d;
    logic [OL-1:0] m;
  } word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    mode;
  logic [LW-1:0] length;
  logic [DW-1:0] cfg_clamp;
  logic [4:0]    cfg_shift;
  logic          busy, done, err;

  vpu_stream_if #(.DW(DW), .IN_LANES(IL), .OUT_LANES(OL)) vif ();

  vpu_stream #(.DW(DW), .IN_LANES(IL), .OUT_LANES(OL), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .length    (length),
    .cfg_clamp (cfg_clamp),
    .cfg_shift (cfg_shift),
    .strm      (vif.slave),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  word_t         exp_q[$];
  logic [WW-1:0] last_d;
  logic [OL-1:0] last_m;
  logic          prev_stall = 1'b0;
  logic [WW-1:0] prev_d;
  logic [OL-1:0] prev_m;

  task automatic chk(input string name, input logic [WW-1:0] got, input logic [WW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  function automatic logic [DW-1:0] mact(input int m, input int c, input int sh, input int x);
    if (m == 1) return (x > 0) ? x : 0;
    if (m == 2) return (x <= 0) ? 0 : ((x > c) ? c : x);
    if (m == 3) return (x < 0) ? (x >>> sh) : x;
    return x;
  endfunction

  // Model: activate the first len elements and cut them into OL-element masked words.
  task automatic model_push(input int m, input int len, input int c, input int sh, input int elems[$]);
    word_t w;
    int    slot;
    w    = '0;
    slot = 0;
    for (int k = 0; k < len; k++) begin
      w.d[slot*DW +: DW] = mact(m, c, sh, elems[k]);
      w.m[slot]          = 1'b1;
      slot++;
      if (slot == OL || k == len - 1) begin
        exp_q.push_back(w);
        w    = '0;
        slot = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", vif.out_valid, 1'b1);
        chk("hold_data", vif.out_data, prev_d);
        chk("hold_mask", vif.out_mask, prev_m);
      end
      if (vif.out_valid) begin
        if (vif.out_ready) begin
          last_d = vif.out_data;
          last_m = vif.out_mask;
          if (exp_q.size() == 0) begin
            chk("unexpected_word", vif.out_valid, 1'b0);
          end else begin
            word_t w;
            w = exp_q.pop_front();
            chk("word_data", vif.out_data, w.d);
            chk("word_mask", vif.out_mask, w.m);
          end
        end
        prev_stall = !vif.out_ready;
        prev_d     = vif.out_data;
        prev_m     = vif.out_mask;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic start_job(input logic [3:0] m, input int len, input int c, input int sh);
    @(posedge clk); #1;
    start     = 1'b1;
    mode      = m;
    length    = LW'(len);
    cfg_clamp = c;
    cfg_shift = 5'(sh);
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send_beat(input int elems[$], input int b);
    logic [IL*DW-1:0] d;
    int               cnt;
    for (int i = 0; i < IL; i++)
      d[i*DW +: DW] = (b*IL + i < elems.size()) ? elems[b*IL + i] : 0;
    vif.in_valid = 1'b1;
    vif.in_data  = d;
    cnt = 0;
    @(negedge clk);
    while (!vif.in_ready && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 300) chk("in_ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    vif.in_valid = 1'b0;
  endtask

  task automatic wait_done(input logic exp_err, input string tag);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!done && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_err"}, err, exp_err);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, {done, err, busy}, 3'b000);
  endtask

  task automatic run_job(input logic [3:0] m, input int len, input int c, input int sh,
                         input int elems[$], input bit poke, input string tag);
    logic illegal;
    illegal = (m > 4'd3);
    if (!illegal) model_push(m, len, c, sh, elems);
    start_job(m, len, c, sh);
    if (!illegal) begin
      for (int b = 0; b < (len + IL - 1) / IL; b++) begin
        if (poke && b == 1) begin
          start  = 1'b1;
          mode   = 4'd3;
          length = 8'd1;
        end
        send_beat(elems, b);
        start = 1'b0;
      end
    end
    wait_done(illegal, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            q1[$], q2[$], q3[$], q4[$], q5[$], q6[$], q7[$], q8[$];
    logic [WW-1:0] lit;
    int            cnt;

    rst = 1'b1; start = 1'b0; mode = '0; length = '0; cfg_clamp = '0; cfg_shift = '0;
    vif.in_valid = 1'b0; vif.in_data = '0; vif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {vif.in_ready, vif.out_valid, busy, done, err}, 5'b0);
    chk("reset_data", vif.out_data, '0);
    chk("reset_mask", vif.out_mask, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ReLU, full word
    q1 = '{5, -3, 0, 7, -1, 2, 9, -8};
    model_push(1, 8, 0, 0, q1);
    lit = {32'd0, 32'd9, 32'd2, 32'd0, 32'd7, 32'd0, 32'd0, 32'd5};
    chk("model_relu_word", exp_q[$].d, lit);
    void'(exp_q.pop_back());
    run_job(4'd1, 8, 0, 0, q1, 1'b0, "relu8");
    chk("relu8_word", last_d, lit);
    chk("relu8_mask", last_m, 8'hFF);

    // pass, partial word with discarded lane; start while busy poked mid-job
    q2 = '{1, 2, 3, 4, 5, 99};
    run_job(4'd0, 5, 0, 0, q2, 1'b1, "pass5");
    chk("pass5_word", last_d, {32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
    chk("pass5_mask", last_m, 8'h1F);

    // clamp
    q3 = '{10, -2, 6, 3, 7, 0};
    run_job(4'd2, 6, 6, 0, q3, 1'b0, "clamp6");
    chk("clamp6_word", last_d, {32'd0, 32'd6, 32'd3, 32'd6, 32'd0, 32'd6});
    chk("clamp6_mask", last_m, 8'h3F);

    // leaky
    q4 = '{-16, -1, 5, -7};
    run_job(4'd3, 4, 0, 2, q4, 1'b0, "leaky4");
    chk("leaky4_word", last_d, {32'hFFFFFFFE, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFC});
    chk("leaky4_mask", last_m, 8'h0F);

    // backpressure on the first of two words
    q5 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    vif.out_ready = 1'b0;
    fork
      run_job(4'd0, 16, 0, 0, q5, 1'b0, "bp16");
      begin
        cnt = 0;
        @(negedge clk);
        while (!vif.out_valid && cnt < 300) begin
          @(negedge clk);
          cnt++;
        end
        chk("bp16_first_valid", vif.out_valid, 1'b1);
        chk("bp16_stall_in_ready", vif.in_ready, 1'b0);
        repeat (4) begin
          @(negedge clk);
          chk("bp16_stall_in_ready", vif.in_ready, 1'b0);
        end
        @(posedge clk); #1;
        vif.out_ready = 1'b1;
      end
    join
    chk("bp16_second_word", last_d, {32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10, 32'd9});

    // illegal mode and zero length
    q6 = {};
    run_job(4'd7, 4, 0, 0, q6, 1'b0, "illegal");
    run_job(4'd1, 0, 0, 0, q6, 1'b0, "len0");

    // reset mid-job drops the partial word
    q7 = '{1, 2, 3, 4, 5, 6};
    start_job(4'd1, 8, 0, 0);
    for (int b = 0; b < 3; b++) send_beat(q7, b);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctrl", {vif.in_ready, vif.out_valid, busy, done, err}, 5'b0);
    chk("rst_mid_data", vif.out_data, '0);
    chk("rst_mid_mask", vif.out_mask, '0);
    repeat (5) begin
      @(negedge clk);
      chk("rst_mid_no_done", done, 1'b0);
    end

    q8 = '{-4, 8, -9, 77};
    run_job(4'd1, 3, 0, 0, q8, 1'b0, "after_rst");
    chk("after_rst_word", last_d, {32'd0, 32'd8, 32'd0});
    chk("after_rst_mask", last_m, 8'h07);

    repeat (3) @(negedge clk);
    chk("model_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
